// File: rtl/lpd_pkg.sv
// Shared types and helpers for the multi-pattern detector.
// Holds the FSM state encoding, the scan-mode encoding and the index-width helper.
package lpd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ANY = 1'b0;
  localparam logic MODE_SEQ = 1'b1;

  // Index ports stay at least one bit wide even when a single pattern exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lpd_pat_match.sv
// Combinational compare of one word against every value/mask pair.
// A pattern with an all-zero mask never matches.
module lpd_pat_match
  import lpd_pkg::*;
#(
  parameter int DATA_W  = 10,
  parameter int NUM_PAT = 4,
  parameter int IDX_W   = idx_w(NUM_PAT)
) (
  input  logic [DATA_W-1:0]               data_i,
  input  logic [NUM_PAT-1:0][DATA_W-1:0]  pat_val_i,
  input  logic [NUM_PAT-1:0][DATA_W-1:0]  pat_mask_i,
  output logic [NUM_PAT-1:0]              match_o,
  output logic [IDX_W-1:0]                low_idx_o
);

  for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_cmp
    assign match_o[gi] = (|pat_mask_i[gi]) &&
                         !(|((data_i ^ pat_val_i[gi]) & pat_mask_i[gi]));
  end

  // Walk downwards so the lowest matching index is the one left standing.
  always_comb begin
    low_idx_o = '0;
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (match_o[i]) low_idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/lpd_multi.sv
// Multi-pattern detector: scans addresses 0..DEPTH-1 once per start, matching
// each word against the pattern registers either as alternatives or as an ordered run.
module lpd_multi
  import lpd_pkg::*;
#(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int NUM_PAT = 4,
  parameter int CNT_W   = 4,
  localparam int IDX_W  = idx_w(NUM_PAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              pat_load,
  input  logic [IDX_W-1:0]  pat_idx,
  input  logic [DATA_W-1:0] pat_val,
  input  logic [DATA_W-1:0] pat_mask,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              flag,
  output logic [IDX_W-1:0]  flag_idx,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              fin
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  K_LAST    = IDX_W'(NUM_PAT - 1);

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic                        flag_q, flag_d;
  logic [IDX_W-1:0]            flag_idx_q, flag_idx_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        mode_q, mode_d;
  logic [IDX_W-1:0]            k_q, k_d;
  logic [NUM_PAT-1:0][DATA_W-1:0] pat_val_q, pat_mask_q;

  logic [NUM_PAT-1:0] match;
  logic [IDX_W-1:0]   low_idx;
  logic               match_k;
  logic               seq_mode;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;

  // Writes to an index beyond NUM_PAT-1 find no matching slot and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_val_q  <= '0;
      pat_mask_q <= '0;
    end else if (pat_load && state_q != SCAN) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        if (pat_idx == IDX_W'(i)) begin
          pat_val_q[i]  <= pat_val;
          pat_mask_q[i] <= pat_mask;
        end
      end
    end
  end

  lpd_pat_match #(
    .DATA_W  (DATA_W),
    .NUM_PAT (NUM_PAT),
    .IDX_W   (IDX_W)
  ) u_match (
    .data_i     (data),
    .pat_val_i  (pat_val_q),
    .pat_mask_i (pat_mask_q),
    .match_o    (match),
    .low_idx_o  (low_idx)
  );

  always_comb begin
    match_k = 1'b0;
    for (int i = 0; i < NUM_PAT; i++) begin
      if (k_q == IDX_W'(i)) match_k = match[i];
    end
  end

  // With a single pattern the ordered mode collapses onto the any-of behaviour.
  assign seq_mode = (mode_q == MODE_SEQ) && (NUM_PAT > 1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    flag_d     = flag_q;
    flag_idx_d = flag_idx_q;
    count_d    = count_q;
    mode_d     = mode_q;
    k_d        = k_q;
    hit        = 1'b0;
    hit_idx    = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = SCAN;
          addr_d     = '0;
          flag_d     = 1'b0;
          flag_idx_d = '0;
          count_d    = '0;
          k_d        = '0;
          mode_d     = mode;
        end
      end
      SCAN: begin
        if (seq_mode) begin
          if (match_k) begin
            if (k_q == K_LAST) begin
              hit     = 1'b1;
              hit_idx = K_LAST;
              k_d     = match[0] ? IDX_W'(1) : '0;
            end else begin
              k_d = k_q + IDX_W'(1);
            end
          end else begin
            k_d = match[0] ? IDX_W'(1) : '0;
          end
        end else begin
          hit     = |match;
          hit_idx = low_idx;
        end
        flag_d     = hit;
        flag_idx_d = hit_idx;
        if (hit && count_q != '1) count_d = count_q + CNT_W'(1);
        if (addr_q == ADDR_LAST) state_d = DONE;
        else                     addr_d  = addr_q + ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      flag_q     <= 1'b0;
      flag_idx_q <= '0;
      count_q    <= '0;
      mode_q     <= MODE_ANY;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      flag_q     <= flag_d;
      flag_idx_q <= flag_idx_d;
      count_q    <= count_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
    end
  end

  assign addr     = addr_q;
  assign flag     = flag_q;
  assign flag_idx = flag_idx_q;
  assign count    = count_q;
  assign busy     = (state_q == SCAN);
  assign fin      = (state_q == DONE);

endmodule

// File: tb/tb_lpd_multi.sv
// Scoreboard bench for lpd_multi with DEPTH=16, NUM_PAT=3, CNT_W=2.
// Expected per-word results come from a small reference model run over the bench memory.
module tb_lpd_multi;

  logic       clk = 1'b0;
  logic       rst, start, mode, pat_load;
  logic [1:0] pat_idx;
  logic [9:0] pat_val, pat_mask;
  logic [3:0] addr;
  logic [9:0] data;
  logic       flag;
  logic [1:0] flag_idx;
  logic [1:0] count;
  logic       busy, fin;

  lpd_multi #(
    .DATA_W(10), .ADDR_W(4), .DEPTH(16), .NUM_PAT(3), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pat_load(pat_load),
    .pat_idx(pat_idx), .pat_val(pat_val), .pat_mask(pat_mask),
    .addr(addr), .data(data), .flag(flag), .flag_idx(flag_idx),
    .count(count), .busy(busy), .fin(fin)
  );

  always #5 clk = ~clk;

  logic [9:0] mem [16];
  assign data = mem[addr];

  typedef struct {
    logic       f;
    logic [1:0] i;
    logic [1:0] c;
  } exp_t;
  exp_t sb[$];

  logic [9:0] mv [3];
  logic [9:0] mm [3];
  logic       obs_f [16];
  logic [1:0] obs_i [16];
  int         nflags;
  int         n_pass = 0;
  int         n_chk  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int p = 0; p < 3; p++) begin
      mv[p] = '0;
      mm[p] = '0;
    end
  endtask

  task automatic mem_fill(input logic [9:0] v);
    for (int n = 0; n < 16; n++) mem[n] = v;
  endtask

  task automatic model_push(input logic m);
    int k;
    int c;
    exp_t e;
    logic [2:0] hv;
    k = 0;
    c = 0;
    for (int n = 0; n < 16; n++) begin
      for (int p = 0; p < 3; p++)
        hv[p] = (mm[p] != 10'd0) && (((mem[n] ^ mv[p]) & mm[p]) == 10'd0);
      e.f = 1'b0;
      e.i = 2'd0;
      if (!m) begin
        if (hv != 3'b000) begin
          e.f = 1'b1;
          e.i = hv[0] ? 2'd0 : (hv[1] ? 2'd1 : 2'd2);
        end
      end else if (hv[k]) begin
        if (k == 2) begin
          e.f = 1'b1;
          e.i = 2'd2;
          k = hv[0] ? 1 : 0;
        end else begin
          k = k + 1;
        end
      end else begin
        k = hv[0] ? 1 : 0;
      end
      if (e.f && c < 3) c = c + 1;
      e.c = 2'(c);
      sb.push_back(e);
    end
  endtask

  task automatic load_pat(input logic [1:0] idx, input logic [9:0] v, input logic [9:0] m);
    pat_load = 1'b1;
    pat_idx  = idx;
    pat_val  = v;
    pat_mask = m;
    tick();
    pat_load = 1'b0;
    if (idx < 2'd3) begin
      mv[idx] = v;
      mm[idx] = m;
    end
    $display("load   idx=%0d val=%03h mask=%03h", idx, v, m);
  endtask

  // Starts a scan (optionally with a same-cycle pattern write) and consumes the scoreboard.
  // ignore_at >= 0 pulses start+pat_load mid-scan, which the DUT must ignore.
  task automatic run_scan(input logic m, input logic with_load, input logic [1:0] li,
                          input logic [9:0] lv, input logic [9:0] lm, input int ignore_at);
    exp_t e;
    start = 1'b1;
    mode  = m;
    if (with_load) begin
      pat_load = 1'b1;
      pat_idx  = li;
      pat_val  = lv;
      pat_mask = lm;
      mv[li]   = lv;
      mm[li]   = lm;
    end
    sb.delete();
    model_push(m);
    tick();
    start    = 1'b0;
    pat_load = 1'b0;
    nflags   = 0;
    n_chk++;
    if (busy !== 1'b1 || addr !== 4'd0) $display("FAIL scan_start: busy=%b addr=%0d want busy=1 addr=0", busy, addr);
    else n_pass++;
    for (int n = 0; n < 16; n++) begin
      if (n == ignore_at) begin
        start    = 1'b1;
        pat_load = 1'b1;
        pat_idx  = 2'd0;
        pat_val  = ~mv[0];
        pat_mask = 10'h3FF;
      end
      tick();
      start    = 1'b0;
      pat_load = 1'b0;
      obs_f[n] = flag;
      obs_i[n] = flag_idx;
      if (flag === 1'b1) nflags++;
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_empty: word %0d has no expected entry", n);
      end else begin
        e = sb.pop_front();
        if (flag !== e.f || flag_idx !== e.i || count !== e.c)
          $display("FAIL word%0d: flag=%b idx=%0d count=%0d want flag=%b idx=%0d count=%0d",
                   n, flag, flag_idx, count, e.f, e.i, e.c);
        else n_pass++;
      end
      n_chk++;
      if (fin !== (n == 15) || busy !== (n != 15))
        $display("FAIL word%0d_status: fin=%b busy=%b want fin=%b busy=%b", n, fin, busy, n == 15, n != 15);
      else n_pass++;
    end
    n_chk++;
    if (addr !== 4'd15) $display("FAIL addr_hold: addr=%0d want 15", addr);
    else n_pass++;
    $display("scan   mode=%0d flags=%0d count=%0d", m, nflags, count);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_chk++;
    if (addr !== 4'd0 || flag !== 1'b0 || flag_idx !== 2'd0 || count !== 2'd0 || busy !== 1'b0 || fin !== 1'b0)
      $display("FAIL %s: addr=%0d flag=%b idx=%0d count=%0d busy=%b fin=%b want all 0",
               tag, addr, flag, flag_idx, count, busy, fin);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    model_clear();
    $display("reset  done");
  endtask

  task automatic test_no_mask();
    for (int n = 0; n < 16; n++) mem[n] = 10'($urandom);
    run_scan(1'b0, 1'b0, 2'd0, 10'd0, 10'd0, -1);
    n_chk++;
    if (nflags != 0 || count !== 2'd0) $display("FAIL no_mask: flags=%0d count=%0d want 0 0", nflags, count);
    else n_pass++;
  endtask

  task automatic test_any();
    mem_fill(10'h000);
    mem[4] = 10'h3A5;
    mem[9] = 10'h115;
    load_pat(2'd0, 10'h3A5, 10'h3FF);
    load_pat(2'd1, 10'h005, 10'h00F);
    run_scan(1'b0, 1'b0, 2'd0, 10'd0, 10'd0, -1);
    n_chk++;
    if (obs_f[4] !== 1'b1 || obs_i[4] !== 2'd0) $display("FAIL any_word4: flag=%b idx=%0d want 1 0", obs_f[4], obs_i[4]);
    else n_pass++;
    n_chk++;
    if (obs_f[9] !== 1'b1 || obs_i[9] !== 2'd1) $display("FAIL any_word9: flag=%b idx=%0d want 1 1", obs_f[9], obs_i[9]);
    else n_pass++;
    n_chk++;
    if (count !== 2'd2) $display("FAIL any_count: count=%0d want 2", count);
    else n_pass++;
  endtask

  task automatic test_seq();
    mem_fill(10'h000);
    mem[2] = 10'h0AA; mem[3] = 10'h0AA; mem[4] = 10'h0BB; mem[5] = 10'h0CC;
    mem[6] = 10'h0AA; mem[7] = 10'h0BB; mem[8] = 10'h0CC;
    load_pat(2'd0, 10'h0AA, 10'h3FF);
    load_pat(2'd1, 10'h0BB, 10'h3FF);
    load_pat(2'd2, 10'h0CC, 10'h3FF);
    run_scan(1'b1, 1'b0, 2'd0, 10'd0, 10'd0, -1);
    n_chk++;
    if (obs_f[5] !== 1'b1 || obs_i[5] !== 2'd2) $display("FAIL seq_word5: flag=%b idx=%0d want 1 2", obs_f[5], obs_i[5]);
    else n_pass++;
    n_chk++;
    if (obs_f[8] !== 1'b1 || obs_i[8] !== 2'd2) $display("FAIL seq_word8: flag=%b idx=%0d want 1 2", obs_f[8], obs_i[8]);
    else n_pass++;
    n_chk++;
    if (nflags != 2 || count !== 2'd2) $display("FAIL seq_count: flags=%0d count=%0d want 2 2", nflags, count);
    else n_pass++;
  endtask

  task automatic test_saturate();
    mem_fill(10'h000);
    for (int n = 1; n < 10; n += 2) mem[n] = 10'h3A5;
    load_pat(2'd0, 10'h3A5, 10'h3FF);
    run_scan(1'b0, 1'b0, 2'd0, 10'd0, 10'd0, -1);
    n_chk++;
    if (nflags != 5 || count !== 2'd3) $display("FAIL saturate: flags=%0d count=%0d want 5 3", nflags, count);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    mem_fill(10'h3A5);
    start = 1'b1;
    mode  = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && addr !== 4'd7; i++) tick();
    n_chk++;
    if (addr !== 4'd7) $display("FAIL rst_mid_reach: addr=%0d want 7", addr);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_mid_outputs");
    model_clear();
    run_scan(1'b0, 1'b0, 2'd0, 10'd0, 10'd0, -1);
    n_chk++;
    if (nflags != 0 || count !== 2'd0) $display("FAIL rst_mid_masks: flags=%0d count=%0d want 0 0", nflags, count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    mem_fill(10'h000);
    mem[0]  = 10'h111;
    mem[10] = 10'h3A5;
    load_pat(2'd0, 10'h3A5, 10'h3FF);
    run_scan(1'b0, 1'b0, 2'd0, 10'd0, 10'd0, 5);
    n_chk++;
    if (obs_f[10] !== 1'b1 || nflags != 1) $display("FAIL ignore_in_scan: word10=%b flags=%0d want 1 1", obs_f[10], nflags);
    else n_pass++;
    run_scan(1'b0, 1'b1, 2'd0, 10'h111, 10'h3FF, -1);
    n_chk++;
    if (obs_f[0] !== 1'b1 || obs_i[0] !== 2'd0 || obs_f[10] !== 1'b0)
      $display("FAIL load_with_start: word0=%b idx=%0d word10=%b want 1 0 0", obs_f[0], obs_i[0], obs_f[10]);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; pat_load = 1'b0;
    pat_idx = '0; pat_val = '0; pat_mask = '0;
    mem_fill(10'h000);
    model_clear();
    test_reset();
    test_no_mask();
    test_any();
    test_seq();
    test_saturate();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/lpd_multi.md
# lpd_multi

Parametrised multi-pattern detector, the next generation of the single-pattern LPD. Scans a word-addressed source memory from address 0 to DEPTH-1 and matches each word against NUM_PAT programmable masked patterns, either as independent alternatives or as an ordered consecutive sequence. Reports a per-word detection flag, the index of the matched pattern, and a saturating detection count. Sits between the pattern ROM/RAM read port and the host control logic.

## Interface
- DATA_W, 10: width of a scanned word.
- ADDR_W, 10: address width.
- DEPTH, 1024: number of words scanned, 2..2^ADDR_W.
- NUM_PAT, 4: number of pattern registers, 1..16.
- CNT_W, 4: detection counter width.

- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; accepted in IDLE or DONE only.
- mode  in  1  0 = any-of, 1 = ordered sequence; sampled when start is accepted.
- pat_load  in  1  write a pattern register; accepted in IDLE or DONE only.
- pat_idx  in  $clog2(NUM_PAT) (min 1)  pattern register selected by pat_load.
- pat_val  in  DATA_W  pattern value.
- pat_mask  in  DATA_W  compare mask; 1 = bit compared.
- addr  out  ADDR_W  read address to the source memory.
- data  in  DATA_W  word at addr, valid combinationally in the same cycle.
- flag  out  1  detection on the word sampled at the previous edge.
- flag_idx  out  $clog2(NUM_PAT) (min 1)  pattern index tied to flag; 0 when flag = 0.
- count  out  CNT_W  detections this scan; saturates at 2^CNT_W-1.
- busy  out  1  high in SCAN.
- fin  out  1  high in DONE.

## Operation
- States: IDLE (after reset), SCAN, DONE.
- IDLE/DONE + start: go to SCAN. Clear addr, count, flag, flag_idx and the sequence pointer. Latch mode.
- SCAN: each edge samples data at addr, updates flag/flag_idx/count, and increments addr. At the edge that samples addr = DEPTH-1, go to DONE. addr holds DEPTH-1.
- DONE: hold count, addr, and the last flag/flag_idx. Stay until start or rst.
- Pattern p matches when ((data ^ pat_val[p]) & pat_mask[p]) == 0 and pat_mask[p] != 0. A zero mask disables the pattern.
- Mode 0: flag = any pattern matches. flag_idx = lowest matching index. count increments by 1 per flagged word, whatever the number of matches.
- Mode 1: the sequence pointer k (0..NUM_PAT-1) tracks progress.
  - If pattern k matches: k advances.
  - When k = NUM_PAT-1 matches: flag = 1, flag_idx = NUM_PAT-1, count increments, and k restarts. Restart rule: k = 1 if pattern 0 matches the same word and NUM_PAT > 1, else 0.
  - On a mismatch, k = 1 if pattern 0 matches the current word, else k = 0. No further fallback.
  - NUM_PAT = 1 degenerates to mode 0.
- start or pat_load during SCAN: ignored. pat_load with pat_idx >= NUM_PAT: ignored.
- start with pat_load in the same cycle (IDLE/DONE): the pattern write takes effect and the scan starts. The first compare uses the new value.

## Timing
- Reset values: addr = 0, flag = 0, flag_idx = 0, count = 0, busy = 0, fin = 0, all pattern masks = 0, state = IDLE.
- rst mid-scan aborts the scan. All registers return to their reset values on that edge.
- start accepted at edge T: busy = 1 and addr = 0 after T. The word at addr n is sampled at edge T+1+n. Its flag/count are visible after that edge.
- Scan length: exactly DEPTH cycles from start acceptance to fin = 1.
- fin and the last word's flag become visible after the same edge.
- Count saturation: at 2^CNT_W-1, further detections still pulse flag but count holds.

## Structure
- Package lpd_pkg:
  - state enum (IDLE, SCAN, DONE);
  - mode encoding (MODE_ANY = 0, MODE_SEQ = 1);
  - function for index width, $clog2 with a minimum of 1.
- Sub-module lpd_pat_match: combinational match of one word against NUM_PAT value/mask pairs. Outputs a NUM_PAT-bit match vector and the lowest-match index.
- Top lpd_multi: pattern register file, FSM, address counter, sequence pointer, saturating counter.

## Test plan
- Reset, then scan with DEPTH = 16, all masks 0 -> flag never 1; count = 0; fin rises exactly 16 cycles after start; addr holds 15.
- Mode 0: pat0 = 10'h3A5 with mask 10'h3FF, pat1 = 10'h005 with mask 10'h00F; word 10'h3A5 at addr 4 -> flag_idx = 0 after the edge sampling addr 4; count increments once.
- Mode 1, NUM_PAT = 3, patterns A,B,C: data A,A,B,C,A,B,C -> flags on the 4th and 7th words; count = 2; the extra A restarts with k = 1.
- CNT_W = 2, 5 matching words -> flag pulses 5 times; count sticks at 3.
- rst mid-scan at addr 7 -> outputs reset on the next edge; masks cleared; a new start rescans from addr 0.
- pat_load and start asserted during SCAN -> no effect; pat_load together with start in DONE -> the new pattern is used from addr 0.
